// File: rtl/polaris_irq_pkg.sv
// Shared constants and types for the Polaris multi-source interrupt controller.
// Holds CSR offsets relative to BASE, the claim state enum, and bus/id widths.
package polaris_irq_pkg;

   localparam int unsigned ID_W   = 5;
   localparam int unsigned CSR_AW = 12;
   localparam int unsigned CSR_DW = 64;

   localparam logic [1:0] OFF_PEND  = 2'd0;
   localparam logic [1:0] OFF_ENA   = 2'd1;
   localparam logic [1:0] OFF_CLAIM = 2'd2;
   localparam logic [1:0] OFF_TYPE  = 2'd3;

   typedef enum logic {
      IDLE    = 1'b0,
      CLAIMED = 1'b1
   } state_e;

endpackage

// File: rtl/polaris_irq_sync.sv
// Per-source synchroniser: two flops bring src_i into the clk_i domain.
// Optional macro POLARIS_IRQ_EDGE_EN adds a third flop and a rising-edge pulse.
// Ports:
//   clk_i, reset_ni  clock, async active-low reset
//   src_i            raw asynchronous interrupt line
//   lvl_o            synchronised level
//   rise_o           one-cycle pulse on synchronised 0->1 (edge builds only)
module polaris_irq_sync
   import polaris_irq_pkg::*;
(
   input  logic clk_i,
   input  logic reset_ni,
   input  logic src_i,
`ifdef POLARIS_IRQ_EDGE_EN
   output logic rise_o,
`endif
   output logic lvl_o
);

   logic meta_q, meta_d;
   logic lvl_q, lvl_d;

   // Two-stage synchroniser chain
   always_comb begin
      meta_d = src_i;
      lvl_d  = meta_q;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         meta_q <= 1'b0;
         lvl_q  <= 1'b0;
      end else begin
         meta_q <= meta_d;
         lvl_q  <= lvl_d;
      end
   end

   assign lvl_o = lvl_q;

`ifdef POLARIS_IRQ_EDGE_EN
   logic prev_q, prev_d;

   // Previous synchronised level for rising-edge detection
   always_comb prev_d = lvl_q;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) prev_q <= 1'b0;
      else           prev_q <= prev_d;
   end

   assign rise_o = lvl_q & ~prev_q;
`endif

endmodule

// File: rtl/polaris_irq_ctrl.sv
// Multi-source interrupt controller feeding the Polaris core's single irq_i.
// Synchronises NSRC lines, masks them, picks the lowest-numbered pending source and
// runs a claim/complete handshake over the CSR bus (IPEND, IENA, ICLAIM, ITYPE at BASE..BASE+3).
// Optional macro POLARIS_IRQ_EDGE_EN enables per-source rising-edge (sticky) mode via ITYPE.
// Ports:
//   clk_i, reset_ni        clock, async active-low reset
//   src_i[NSRC]            raw asynchronous interrupt lines
//   irq_o                  interrupt request to the core
//   cause_o[5]             claimed id while CLAIMED, else current winner id (0 = none)
//   cadr_i/coe_i/cwe_i     CSR address, read strobe, write strobe
//   cdat_i/cdat_o          CSR write/read data (read is combinational, 0 on miss)
//   cvalid_o               address hits one of the four CSRs
module polaris_irq_ctrl
   import polaris_irq_pkg::*;
#(
   parameter int unsigned      NSRC = 8,
   parameter logic [11:0]      BASE = 12'hBC0
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic [NSRC-1:0]   src_i,
   output logic              irq_o,
   output logic [ID_W-1:0]   cause_o,
   input  logic [CSR_AW-1:0] cadr_i,
   input  logic              coe_i,
   input  logic              cwe_i,
   input  logic [CSR_DW-1:0] cdat_i,
   output logic [CSR_DW-1:0] cdat_o,
   output logic              cvalid_o
);

   logic [NSRC-1:0]   lvl;
   logic [NSRC-1:0]   pend;
   logic [NSRC-1:0]   type_rd;
   logic [NSRC-1:0]   ena_q, ena_d;
   state_e            state_q, state_d;
   logic [ID_W-1:0]   claim_id_q, claim_id_d;
   logic [ID_W-1:0]   winner;
   logic [ID_W-1:0]   cur_id;
   logic [CSR_AW-1:0] off;
   logic [1:0]        sel;
   logic              hit;
   logic              csr_wr;
   logic              claim_evt;
   logic              cmpl_evt;
   logic              unused_cdat;
`ifdef POLARIS_IRQ_EDGE_EN
   logic [NSRC-1:0]   rise;
   logic [NSRC-1:0]   type_q, type_d;
   logic [NSRC-1:0]   epend_q, epend_d;
   logic [NSRC-1:0]   clr;
`endif

   for (genvar gi = 0; gi < NSRC; gi++) begin : g_sync
      polaris_irq_sync u_sync (
         .clk_i    (clk_i),
         .reset_ni (reset_ni),
         .src_i    (src_i[gi]),
`ifdef POLARIS_IRQ_EDGE_EN
         .rise_o   (rise[gi]),
`endif
         .lvl_o    (lvl[gi])
      );
   end

   // CSR decode; the subtraction wraps so only BASE..BASE+3 lands below 4
   assign off         = cadr_i - BASE;
   assign hit         = (off < CSR_AW'(4));
   assign sel         = off[1:0];
   assign csr_wr      = cwe_i & hit;
   assign unused_cdat = ^cdat_i;

   // Priority encoder: lowest index wins, reported as index+1
   always_comb begin
      winner = '0;
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
         if (pend[i] && ena_q[i]) winner = ID_W'(i + 1);
      end
   end

   assign claim_evt = coe_i & hit & (sel == OFF_CLAIM) & (state_q == IDLE) & (winner != '0);
   assign cmpl_evt  = csr_wr & (sel == OFF_CLAIM) & (state_q == CLAIMED) &
                      (cdat_i[ID_W-1:0] == claim_id_q);

   // Claim FSM next state
   always_comb begin
      state_d    = state_q;
      claim_id_d = claim_id_q;
      case (state_q)
         IDLE: begin
            if (claim_evt) begin
               state_d    = CLAIMED;
               claim_id_d = winner;
            end
         end
         CLAIMED: begin
            if (cmpl_evt) begin
               state_d    = IDLE;
               claim_id_d = '0;
            end
         end
         default: begin
            state_d    = IDLE;
            claim_id_d = '0;
         end
      endcase
   end

   // Enable register writes
   always_comb begin
      ena_d = ena_q;
      if (csr_wr && (sel == OFF_ENA)) ena_d = cdat_i[NSRC-1:0];
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= IDLE;
         claim_id_q <= '0;
         ena_q      <= '0;
      end else begin
         state_q    <= state_d;
         claim_id_q <= claim_id_d;
         ena_q      <= ena_d;
      end
   end

`ifdef POLARIS_IRQ_EDGE_EN
   // Edge-mode pending: a new rising edge beats a same-cycle W1C or claim clear
   always_comb begin
      type_d = type_q;
      if (csr_wr && (sel == OFF_TYPE)) type_d = cdat_i[NSRC-1:0];
      clr = '0;
      if (csr_wr && (sel == OFF_PEND)) clr = cdat_i[NSRC-1:0];
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (claim_evt && (winner == ID_W'(i + 1))) clr[i] = 1'b1;
      end
      epend_d = type_q & (rise | (epend_q & ~clr));
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         type_q  <= '0;
         epend_q <= '0;
      end else begin
         type_q  <= type_d;
         epend_q <= epend_d;
      end
   end

   assign pend    = (type_q & epend_q) | (~type_q & lvl);
   assign type_rd = type_q;
`else
   assign pend    = lvl;
   assign type_rd = '0;
`endif

   assign cur_id   = (state_q == CLAIMED) ? claim_id_q : winner;
   assign irq_o    = (state_q == IDLE) & (|(pend & ena_q));
   assign cause_o  = cur_id;
   assign cvalid_o = hit;

   // CSR read mux, zero-extended, zero on miss
   always_comb begin
      cdat_o = '0;
      if (hit) begin
         case (sel)
            OFF_PEND:  cdat_o = CSR_DW'(pend);
            OFF_ENA:   cdat_o = CSR_DW'(ena_q);
            OFF_CLAIM: cdat_o = CSR_DW'(cur_id);
            default:   cdat_o = CSR_DW'(type_rd);
         endcase
      end
   end

endmodule

// File: tb/tb_polaris_irq_ctrl.sv
// Self-checking bench for polaris_irq_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model. Honors POLARIS_IRQ_EDGE_EN when defined.
module tb_polaris_irq_ctrl;

   localparam logic [11:0] BASE = 12'hBC0;

   logic        clk;
   logic        rst_n;
   logic [7:0]  src;
   logic        irq;
   logic [4:0]  cause;
   logic [11:0] cadr;
   logic        coe;
   logic        cwe;
   logic [63:0] cdat;
   logic [63:0] rdat;
   logic        cvalid;

   int checks = 0;
   int passed = 0;

   polaris_irq_ctrl #(.NSRC(8), .BASE(BASE)) dut (
      .clk_i    (clk),
      .reset_ni (rst_n),
      .src_i    (src),
      .irq_o    (irq),
      .cause_o  (cause),
      .cadr_i   (cadr),
      .coe_i    (coe),
      .cwe_i    (cwe),
      .cdat_i   (cdat),
      .cdat_o   (rdat),
      .cvalid_o (cvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   logic [7:0] m_samp, m_lvl, m_lvl_prev, m_ena, m_type, m_epend;
   logic       m_claimed;
   logic [4:0] m_id;

   function automatic logic [7:0] pend_of(input logic [7:0] typ, input logic [7:0] ep,
                                          input logic [7:0] lv);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = typ[i] ? ep[i] : lv[i];
      return r;
   endfunction

   function automatic logic [4:0] winner_of(input logic [7:0] p, input logic [7:0] en);
      for (int i = 0; i < 8; i++) if (p[i] && en[i]) return 5'(i + 1);
      return 5'd0;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      logic [7:0]  p, clr, rise, ep;
      logic [4:0]  w;
      logic [11:0] d;
      logic        h, clm, cmp;
      if (!rst_n) begin
         m_samp <= '0; m_lvl <= '0; m_lvl_prev <= '0; m_ena <= '0;
         m_type <= '0; m_epend <= '0; m_claimed <= 1'b0; m_id <= '0;
      end else begin
         p   = pend_of(m_type, m_epend, m_lvl);
         w   = winner_of(p, m_ena);
         d   = cadr - BASE;
         h   = (cadr >= BASE) && (cadr <= BASE + 12'd3);
         clm = coe && h && (d[1:0] == 2'd2) && !m_claimed && (w != 5'd0);
         cmp = cwe && h && (d[1:0] == 2'd2) && m_claimed && (cdat[4:0] == m_id);
         clr = '0;
         if (cwe && h && (d[1:0] == 2'd0)) clr = cdat[7:0];
         if (clm) clr[w - 5'd1] = 1'b1;
         rise = m_lvl & ~m_lvl_prev;
         for (int i = 0; i < 8; i++) begin
            if (!m_type[i])   ep[i] = 1'b0;
            else if (rise[i]) ep[i] = 1'b1;
            else if (clr[i])  ep[i] = 1'b0;
            else              ep[i] = m_epend[i];
         end
         m_epend    <= ep;
         m_samp     <= src;
         m_lvl      <= m_samp;
         m_lvl_prev <= m_lvl;
         if (cwe && h && (d[1:0] == 2'd1)) m_ena <= cdat[7:0];
`ifdef POLARIS_IRQ_EDGE_EN
         if (cwe && h && (d[1:0] == 2'd3)) m_type <= cdat[7:0];
`endif
         if (clm) begin m_claimed <= 1'b1; m_id <= w; end
         else if (cmp) m_claimed <= 1'b0;
      end
   end

   // ---------------- bus helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      tick();
      rst_n = 1'b0; src = '0; cadr = '0; coe = 1'b0; cwe = 1'b0; cdat = '0;
      tick();
      @(negedge clk); rst_n = 1'b1;
      tick();
   endtask

   task automatic wr(input logic [1:0] o, input logic [63:0] d);
      cadr = BASE + 12'(o); cwe = 1'b1; cdat = d;
      tick();
      cwe = 1'b0; cadr = '0; cdat = '0;
      #1;
   endtask

   task automatic peek(input logic [1:0] o, output logic [63:0] v);
      cadr = BASE + 12'(o); coe = 1'b0;
      #1 v = rdat;
      cadr = '0;
   endtask

   task automatic claim(output logic [63:0] v);
      cadr = BASE + 12'd2; coe = 1'b1;
      #1 v = rdat;
      tick();
      coe = 1'b0; cadr = '0;
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [63:0] v;
      #1;
      checks++; if (irq !== 1'b0) $display("FAIL reset_irq: irq_o=%0b expected 0", irq); else passed++;
      checks++; if (cause !== 5'd0) $display("FAIL reset_cause: cause_o=%0d expected 0", cause); else passed++;
      do_reset();
      peek(2'd1, v);
      checks++; if (v !== 64'd0) $display("FAIL reset_iena: IENA=%0h expected 0", v); else passed++;
      cadr = BASE; #1;
      checks++; if (cvalid !== 1'b1 || rdat !== 64'd0) $display("FAIL reset_ipend: cvalid=%0b IPEND=%0h expected 1/0", cvalid, rdat); else passed++;
      cadr = '0;
   endtask

   task automatic test_level();
      logic [63:0] v;
      do_reset();
      wr(2'd1, 64'h04);
      src = 8'h04;
      tick(); #1;
      checks++; if (irq !== 1'b0) $display("FAIL level_lat1: irq_o=%0b expected 0", irq); else passed++;
      tick(); #1;
      checks++; if (irq !== 1'b1 || cause !== 5'd3) $display("FAIL level_lat2: irq_o=%0b cause=%0d expected 1/3", irq, cause); else passed++;
      claim(v);
      checks++; if (v !== 64'd3) $display("FAIL level_claim: ICLAIM=%0d expected 3", v); else passed++;
      checks++; if (irq !== 1'b0) $display("FAIL level_claimed_irq: irq_o=%0b expected 0", irq); else passed++;
      wr(2'd2, 64'd3);
      checks++; if (irq !== 1'b1) $display("FAIL level_reassert: irq_o=%0b expected 1", irq); else passed++;
   endtask

   task automatic test_priority();
      logic [63:0] v;
      do_reset();
      wr(2'd1, 64'hFF);
      src = 8'h90;
      tick(); tick();
      claim(v);
      checks++; if (v !== 64'd5) $display("FAIL prio_first: ICLAIM=%0d expected 5", v); else passed++;
      wr(2'd2, 64'd5);
      claim(v);
      checks++; if (v !== 64'd5) $display("FAIL prio_held: ICLAIM=%0d expected 5", v); else passed++;
      src = 8'h80;
      wr(2'd2, 64'd5);
      tick();
      claim(v);
      checks++; if (v !== 64'd8 || cause !== 5'd8) $display("FAIL prio_next: ICLAIM=%0d cause=%0d expected 8/8", v, cause); else passed++;
   endtask

   task automatic test_mismatch();
      logic [63:0] v;
      do_reset();
      wr(2'd1, 64'h04);
      src = 8'h04;
      tick(); tick();
      claim(v);
      wr(2'd2, 64'd4);
      checks++; if (cause !== 5'd3 || irq !== 1'b0) $display("FAIL mismatch_stay: cause=%0d irq=%0b expected 3/0", cause, irq); else passed++;
      peek(2'd2, v);
      checks++; if (v !== 64'd3) $display("FAIL mismatch_read: ICLAIM=%0d expected 3", v); else passed++;
      wr(2'd2, 64'd3);
      checks++; if (irq !== 1'b1) $display("FAIL mismatch_complete: irq_o=%0b expected 1", irq); else passed++;
   endtask

   task automatic test_masking();
      logic [63:0] v;
      do_reset();
      src = 8'h01;
      tick(); tick(); tick(); #1;
      checks++; if (irq !== 1'b0) $display("FAIL mask_irq: irq_o=%0b expected 0", irq); else passed++;
      peek(2'd0, v);
      checks++; if (v !== 64'd1) $display("FAIL mask_ipend: IPEND=%0h expected 1", v); else passed++;
      claim(v);
      checks++; if (v !== 64'd0 || cause !== 5'd0) $display("FAIL mask_claim: ICLAIM=%0d cause=%0d expected 0/0", v, cause); else passed++;
      wr(2'd1, 64'h01);
      checks++; if (irq !== 1'b1) $display("FAIL mask_enable: irq_o=%0b expected 1", irq); else passed++;
   endtask

   task automatic test_coincident();
      do_reset();
      wr(2'd1, 64'h04);
      src = 8'h04;
      tick(); tick();
      cadr = BASE + 12'd2; coe = 1'b1; cwe = 1'b1; cdat = 64'd3;
      tick();
      coe = 1'b0; cwe = 1'b0; #1;
      checks++; if (irq !== 1'b0 || cause !== 5'd3) $display("FAIL both_idle: irq=%0b cause=%0d expected 0/3", irq, cause); else passed++;
      coe = 1'b1; cwe = 1'b1;
      tick();
      coe = 1'b0; cwe = 1'b0; cadr = '0; cdat = '0; #1;
      checks++; if (irq !== 1'b1) $display("FAIL both_claimed: irq_o=%0b expected 1", irq); else passed++;
   endtask

   task automatic test_disable_claimed();
      logic [63:0] v;
      do_reset();
      wr(2'd1, 64'h04);
      src = 8'h04;
      tick(); tick();
      claim(v);
      wr(2'd1, 64'h00);
      checks++; if (cause !== 5'd3 || irq !== 1'b0) $display("FAIL dis_claimed: cause=%0d irq=%0b expected 3/0", cause, irq); else passed++;
      wr(2'd2, 64'd3);
      checks++; if (cause !== 5'd0 || irq !== 1'b0) $display("FAIL dis_complete: cause=%0d irq=%0b expected 0/0", cause, irq); else passed++;
   endtask

   task automatic test_edge();
`ifdef POLARIS_IRQ_EDGE_EN
      logic [63:0] v;
      do_reset();
      wr(2'd3, 64'h01);
      wr(2'd1, 64'h01);
      src = 8'h01;
      tick();
      src = 8'h00; #1;
      checks++; if (irq !== 1'b0) $display("FAIL edge_lat1: irq_o=%0b expected 0", irq); else passed++;
      tick(); #1;
      checks++; if (irq !== 1'b0) $display("FAIL edge_lat2: irq_o=%0b expected 0", irq); else passed++;
      tick(); #1;
      checks++; if (irq !== 1'b1) $display("FAIL edge_lat3: irq_o=%0b expected 1", irq); else passed++;
      tick(); tick();
      peek(2'd0, v);
      checks++; if (v !== 64'd1) $display("FAIL edge_sticky: IPEND=%0h expected 1", v); else passed++;
      claim(v);
      peek(2'd0, v);
      checks++; if (v !== 64'd0) $display("FAIL edge_claim_clr: IPEND=%0h expected 0", v); else passed++;
      wr(2'd2, 64'd1);
      src = 8'h01;
      tick();
      src = 8'h00;
      tick();
      wr(2'd0, 64'h01);
      peek(2'd0, v);
      checks++; if (v !== 64'd1) $display("FAIL edge_set_prio: IPEND=%0h expected 1", v); else passed++;
      wr(2'd0, 64'h01);
      peek(2'd0, v);
      checks++; if (v !== 64'd0) $display("FAIL edge_w1c: IPEND=%0h expected 0", v); else passed++;
`endif
   endtask

   task automatic test_reset_mid();
      logic [63:0] v;
      do_reset();
      wr(2'd1, 64'h04);
      src = 8'h04;
      tick(); tick();
      claim(v);
      rst_n = 1'b0;
      #1;
      checks++; if (irq !== 1'b0 || cause !== 5'd0) $display("FAIL rst_mid: irq=%0b cause=%0d expected 0/0", irq, cause); else passed++;
      peek(2'd1, v);
      checks++; if (v !== 64'd0) $display("FAIL rst_mid_iena: IENA=%0h expected 0", v); else passed++;
      @(negedge clk); rst_n = 1'b1;
      cadr = BASE + 12'd2; coe = 1'b1;
      #1;
      checks++; if (rdat !== 64'd0) $display("FAIL rst_first_claim: ICLAIM=%0d expected 0", rdat); else passed++;
      tick();
      coe = 1'b0; cadr = '0;
   endtask

   task automatic test_random();
      logic [7:0]  pe;
      logic [4:0]  w, e_cause;
      logic        e_irq, e_valid;
      logic [63:0] e_rd;
      logic [11:0] d;
      int          r;
      do_reset();
      src = 8'($urandom());
`ifdef POLARIS_IRQ_EDGE_EN
      wr(2'd3, 64'($urandom()));
`endif
      wr(2'd1, 64'($urandom()));
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(2) == 0) src = src ^ (8'd1 << $urandom_range(7));
         coe = 1'b0; cwe = 1'b0; cdat = '0;
         cadr = BASE + 12'($urandom_range(3));
         r = int'($urandom_range(11));
         case (r)
            4, 5: coe = 1'b1;
            6: begin cadr = BASE + 12'd1; cwe = 1'b1; cdat = 64'($urandom()); end
            7: begin cadr = BASE; cwe = 1'b1; cdat = 64'($urandom()); end
            8, 9: begin
               cadr = BASE + 12'd2; cwe = 1'b1;
               cdat = ($urandom_range(1) == 0) ? 64'(m_id) : 64'($urandom_range(9));
            end
            10: begin cadr = BASE + 12'd2; cwe = 1'b1; coe = 1'b1; cdat = 64'(m_id); end
            11: cadr = ($urandom_range(1) == 0) ? BASE + 12'd4 : BASE - 12'd1;
            default: ;
         endcase
         #1;
         pe      = pend_of(m_type, m_epend, m_lvl);
         w       = winner_of(pe, m_ena);
         e_irq   = !m_claimed && ((pe & m_ena) != 8'd0);
         e_cause = m_claimed ? m_id : w;
         d       = cadr - BASE;
         e_valid = (cadr >= BASE) && (cadr <= BASE + 12'd3);
         e_rd    = '0;
         if (e_valid) begin
            case (d[1:0])
               2'd0:    e_rd = 64'(pe);
               2'd1:    e_rd = 64'(m_ena);
               2'd2:    e_rd = 64'(e_cause);
               default: e_rd = 64'(m_type);
            endcase
         end
         checks++; if (irq !== e_irq) $display("FAIL rand_irq[%0d]: irq_o=%0b expected %0b", n, irq, e_irq); else passed++;
         checks++; if (cause !== e_cause) $display("FAIL rand_cause[%0d]: cause_o=%0d expected %0d", n, cause, e_cause); else passed++;
         checks++; if (cvalid !== e_valid) $display("FAIL rand_cvalid[%0d]: cvalid_o=%0b expected %0b", n, cvalid, e_valid); else passed++;
         checks++; if (rdat !== e_rd) $display("FAIL rand_rdata[%0d]: cdat_o=%0h expected %0h", n, rdat, e_rd); else passed++;
         tick();
      end
      coe = 1'b0; cwe = 1'b0; cadr = '0; cdat = '0;
   endtask

   initial begin
      rst_n = 1'b1; src = '0; cadr = '0; coe = 1'b0; cwe = 1'b0; cdat = '0;
      #1 rst_n = 1'b0;
      test_reset();
      test_level();
      test_priority();
      test_mismatch();
      test_masking();
      test_coincident();
      test_disable_claimed();
      test_edge();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
